// File: rtl/sdram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sdram_arbiter                                                 |
// | Purpose  : Time-slotted arbiter sharing one SDRAM controller between     |
// |            video (0), CPU (1), DMA (2) and TS/tile fetch (3). One slot   |
// |            is PERIOD clocks; the grant decision is registered at the     |
// |            last clock of a slot so every sd_* output is valid at cnt==0. |
// | Ports    : clk, rst (async, active high)                                 |
// |            req/rnw/addr/wdata/bsel : per-client request bundle           |
// |            ack/rdy/rdata           : grant pulse, read-valid, read data  |
// |            sd_*                    : controller-side slot interface      |
// | Options  : SDRAM_ARB_REFRESH_SLOT_EN forces a refresh slot after at most |
// |            REF_SLOTS-1 consecutive access slots.                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module sdram_arbiter #(
  parameter int PERIOD    = 8,
  parameter int INIT_HOLD = 4,
  parameter int REF_SLOTS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [3:0]  rnw,
  input  logic [95:0] addr,
  input  logic [63:0] wdata,
  input  logic [7:0]  bsel,
  output logic [3:0]  ack,
  output logic [3:0]  rdy,
  output logic [15:0] rdata,
  output logic        sd_cyc,
  output logic        sd_req,
  output logic        sd_rnw,
  output logic [23:0] sd_a,
  output logic [15:0] sd_di,
  output logic [1:0]  sd_bsel,
  output logic        sd_curr_cpu,
  input  logic [15:0] sd_do
);

  localparam int CW = $clog2(PERIOD);
  localparam int HW = $clog2(INIT_HOLD + 2);
  localparam logic [CW-1:0] C_LAST = CW'(PERIOD - 1);
  localparam logic [HW-1:0] C_HOLD = HW'(INIT_HOLD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          rr_q, rr_d;           // 0: DMA favoured, 1: TS favoured
  logic          sd_cyc_q, sd_cyc_d;
  logic          sd_req_q, sd_req_d;
  logic          sd_rnw_q, sd_rnw_d;
  logic [23:0]   sd_a_q, sd_a_d;
  logic [15:0]   sd_di_q, sd_di_d;
  logic [1:0]    sd_bsel_q, sd_bsel_d;
  logic          sd_curr_cpu_q, sd_curr_cpu_d;
  logic [3:0]    ack_q, ack_d;
  logic [3:0]    rdy_q, rdy_d;
  logic [3:0]    rd_cur_q, rd_cur_d;   // read granted in the current slot
  logic [3:0]    rd_prev_q, rd_prev_d; // read granted in the previous slot

  logic          last;
  logic [HW-1:0] hold_next;
  logic [3:0]    gnt;
  logic [3:0]    gnt_eff;
  logic [3:0]    rnw_eff;
  logic          force_ref;

  assign rdata   = sd_do;
  // Video and TS fetch are read-only; their rnw bits are ignored.
  assign rnw_eff = rnw | 4'b1001;

  // Fixed priority video > CPU, then DMA/TS by round robin.
  always_comb begin
    gnt = 4'b0000;
    if (req[0])                         gnt = 4'b0001;
    else if (req[1])                    gnt = 4'b0010;
    else if (req[2] && (!rr_q || !req[3])) gnt = 4'b0100;
    else if (req[3])                    gnt = 4'b1000;
  end

`ifdef SDRAM_ARB_REFRESH_SLOT_EN
  localparam int RW = $clog2(REF_SLOTS + 1);
  logic [RW-1:0] ref_cnt_q, ref_cnt_d;

  assign force_ref = (ref_cnt_q == RW'(REF_SLOTS - 1));

  always_comb begin
    ref_cnt_d = ref_cnt_q;
    // Counts access slots since the last refresh slot; only slots that
    // actually issue cyc are counted, hold slots are ignored.
    if (last && (hold_next == '0)) begin
      if (|gnt_eff) ref_cnt_d = ref_cnt_q + RW'(1);
      else          ref_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ref_cnt_q <= '0;
    else     ref_cnt_q <= ref_cnt_d;
  end
`else
  // A zero refresh budget degenerates to refresh in every slot.
  assign force_ref = (REF_SLOTS < 1);
`endif

  assign last      = (cnt_q == C_LAST);
  assign hold_next = (hold_q != '0) ? hold_q - HW'(1) : hold_q;
  assign gnt_eff   = force_ref ? 4'b0000 : gnt;

  always_comb begin
    cnt_d         = last ? '0 : cnt_q + CW'(1);
    hold_d        = hold_q;
    rr_d          = rr_q;
    sd_cyc_d      = 1'b0;
    sd_req_d      = sd_req_q;
    sd_rnw_d      = sd_rnw_q;
    sd_a_d        = sd_a_q;
    sd_di_d       = sd_di_q;
    sd_bsel_d     = sd_bsel_q;
    sd_curr_cpu_d = sd_curr_cpu_q;
    ack_d         = 4'b0000;
    rdy_d         = 4'b0000;
    rd_cur_d      = rd_cur_q;
    rd_prev_d     = rd_prev_q;

    // Previous slot's read data appears one clock after cnt==0.
    if (cnt_q == '0) rdy_d = rd_prev_q;

    if (last) begin
      hold_d    = hold_next;
      rd_prev_d = rd_cur_q;
      rd_cur_d  = 4'b0000;
      if (hold_next == '0) begin
        sd_cyc_d      = 1'b1;
        sd_req_d      = |gnt_eff;
        sd_curr_cpu_d = gnt_eff[1];
        ack_d         = gnt_eff;
        for (int n = 0; n < 4; n++) begin
          if (gnt_eff[n]) begin
            sd_rnw_d  = rnw_eff[n];
            sd_a_d    = addr[24*n +: 24];
            sd_di_d   = wdata[16*n +: 16];
            sd_bsel_d = bsel[2*n +: 2];
          end
        end
        rd_cur_d = gnt_eff & rnw_eff;
        // Pointer moves to the client that was not just served.
        if (gnt_eff[2]) rr_d = 1'b1;
        if (gnt_eff[3]) rr_d = 1'b0;
      end else begin
        sd_req_d      = 1'b0;
        sd_curr_cpu_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q         <= '0;
      hold_q        <= C_HOLD;
      rr_q          <= 1'b0;
      sd_cyc_q      <= 1'b0;
      sd_req_q      <= 1'b0;
      sd_rnw_q      <= 1'b1;
      sd_a_q        <= '0;
      sd_di_q       <= '0;
      sd_bsel_q     <= '0;
      sd_curr_cpu_q <= 1'b0;
      ack_q         <= '0;
      rdy_q         <= '0;
      rd_cur_q      <= '0;
      rd_prev_q     <= '0;
    end else begin
      cnt_q         <= cnt_d;
      hold_q        <= hold_d;
      rr_q          <= rr_d;
      sd_cyc_q      <= sd_cyc_d;
      sd_req_q      <= sd_req_d;
      sd_rnw_q      <= sd_rnw_d;
      sd_a_q        <= sd_a_d;
      sd_di_q       <= sd_di_d;
      sd_bsel_q     <= sd_bsel_d;
      sd_curr_cpu_q <= sd_curr_cpu_d;
      ack_q         <= ack_d;
      rdy_q         <= rdy_d;
      rd_cur_q      <= rd_cur_d;
      rd_prev_q     <= rd_prev_d;
    end
  end

  assign sd_cyc      = sd_cyc_q;
  assign sd_req      = sd_req_q;
  assign sd_rnw      = sd_rnw_q;
  assign sd_a        = sd_a_q;
  assign sd_di       = sd_di_q;
  assign sd_bsel     = sd_bsel_q;
  assign sd_curr_cpu = sd_curr_cpu_q;
  assign ack         = ack_q;
  assign rdy         = rdy_q;

endmodule
`default_nettype wire
